// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
// Operation and FSM encodings live here so the top, interface and bench agree.
package div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } div_state_e;

   // Quotient returned on divide-by-zero; sliced down to the datapath width by users.
   localparam logic [63:0] DIV_ZERO_Q = '1;

   function automatic logic op_is_signed(input div_op_e op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Issue / write-back bundle between the register file, hazard logic and div_unit.
// master = issuing side (register file + hazard unit), slave = the divider.
interface div_unit_if
   import div_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
);

   logic                     start_i;
   div_op_e                  op_i;
   logic [DATA_WIDTH-1:0]    rs1_i;
   logic [DATA_WIDTH-1:0]    rs2_i;
   logic [ADDRESS_WIDTH-1:0] rd_i;
   logic                     flush_i;
   logic                     busy_o;
   logic                     we_o;
   logic [ADDRESS_WIDTH-1:0] waddr_o;
   logic [DATA_WIDTH-1:0]    wd_o;

   modport master (
      output start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
      input  busy_o, we_o, waddr_o, wd_o
   );

   modport slave (
      input  start_i, op_i, rs1_i, rs2_i, rd_i, flush_i,
      output busy_o, we_o, waddr_o, wd_o
   );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient LSB when it does not borrow.
module div_step #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic [DATA_WIDTH-1:0] quo_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic [DATA_WIDTH-1:0] quo_o
);

   logic [DATA_WIDTH:0] shifted;
   logic [DATA_WIDTH:0] diff;
   logic                ge;
   logic                unused_diff_msb;

   // The shifted partial remainder needs one extra bit before the compare.
   assign shifted = {rem_i, quo_i[DATA_WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor_i};
   assign ge      = (shifted >= {1'b0, divisor_i});

   // After a successful subtract the result is below the divisor, so its MSB is zero.
   assign unused_diff_msb = diff[DATA_WIDTH];

   assign rem_o = ge ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
   assign quo_o = {quo_i[DATA_WIDTH-2:0], ge};

endmodule

// File: rtl/div_unit.sv
// Iterative restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle,
// with divide-by-zero and signed overflow short-circuited straight to sign fix-up.
module div_unit
   import div_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   div_unit_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam logic [CNT_W-1:0]      LAST_ITER = CNT_W'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] MIN_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] ZERO_Q    = DIV_ZERO_Q[DATA_WIDTH-1:0];

   div_state_e               state_q, state_d;
   div_op_e                  op_q;
   logic [ADDRESS_WIDTH-1:0] rd_q;
   logic                     neg_quo_q, neg_rem_q;
   logic                     div_zero_q, ovf_q;
   logic [DATA_WIDTH-1:0]    rs1_q, divisor_q, quo_q, rem_q;
   logic [CNT_W-1:0]         cnt_q;

   logic                     we_q, we_d;
   logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]    wd_q, wd_d;

   logic                     busy, accept;
   logic                     in_signed, rs1_neg, rs2_neg;
   logic                     in_zero, in_ovf;
   logic [DATA_WIDTH-1:0]    rs1_mag, rs2_mag;
   logic [DATA_WIDTH-1:0]    rem_nxt, quo_nxt;
   logic [DATA_WIDTH-1:0]    result;

   function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
      logic signed [DATA_WIDTH-1:0] s;
      s = $signed(x);
      return $unsigned(-s);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] cond_negate(input logic [DATA_WIDTH-1:0] x,
                                                         input logic neg);
      return neg ? negate(x) : x;
   endfunction

   assign busy   = (state_q != IDLE);
   assign accept = bus.start_i && !busy && !bus.flush_i;

   // Operand decode; the magnitude of the most negative value is its own unsigned image.
   assign in_signed = op_is_signed(bus.op_i);
   assign rs1_neg   = in_signed && bus.rs1_i[DATA_WIDTH-1];
   assign rs2_neg   = in_signed && bus.rs2_i[DATA_WIDTH-1];
   assign rs1_mag   = cond_negate(bus.rs1_i, rs1_neg);
   assign rs2_mag   = cond_negate(bus.rs2_i, rs2_neg);
   assign in_zero   = (bus.rs2_i == '0);
   assign in_ovf    = in_signed && (bus.rs1_i == MIN_NEG) && (bus.rs2_i == '1);

   div_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (divisor_q),
      .rem_o     (rem_nxt),
      .quo_o     (quo_nxt)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = (in_zero || in_ovf) ? FIX : CALC;
            end
         end
         CALC: begin
            if (bus.flush_i) begin
               state_d = IDLE;
            end else if (cnt_q == LAST_ITER) begin
               state_d = FIX;
            end
         end
         FIX:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Sign fix-up and write-back; a flush during FIX drops the write.
   always_comb begin
      if (div_zero_q) begin
         result = op_is_rem(op_q) ? rs1_q : ZERO_Q;
      end else if (ovf_q) begin
         result = op_is_rem(op_q) ? '0 : MIN_NEG;
      end else if (op_is_rem(op_q)) begin
         result = cond_negate(rem_q, neg_rem_q);
      end else begin
         result = cond_negate(quo_q, neg_quo_q);
      end

      we_d    = 1'b0;
      waddr_d = waddr_q;
      wd_d    = wd_q;
      if ((state_q == FIX) && !bus.flush_i && (rd_q != '0)) begin
         we_d    = 1'b1;
         waddr_d = rd_q;
         wd_d    = result;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q       <= OP_DIV;
         rd_q       <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         rs1_q      <= '0;
         divisor_q  <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wd_q       <= '0;
      end else begin
         if (accept) begin
            op_q       <= bus.op_i;
            rd_q       <= bus.rd_i;
            neg_quo_q  <= (bus.op_i == OP_DIV) && (rs1_neg ^ rs2_neg);
            neg_rem_q  <= (bus.op_i == OP_REM) && rs1_neg;
            div_zero_q <= in_zero;
            ovf_q      <= in_ovf;
            rs1_q      <= bus.rs1_i;
            divisor_q  <= rs2_mag;
            quo_q      <= rs1_mag;
            rem_q      <= '0;
            cnt_q      <= '0;
         end else if (state_q == CALC) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
         end
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wd_q    <= wd_d;
      end
   end

   assign bus.busy_o  = busy;
   assign bus.we_o    = we_q;
   assign bus.waddr_o = waddr_q;
   assign bus.wd_o    = wd_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vector table, flush/rd0/back-to-back/reset sequences,
// and randomized operations checked against a plain-arithmetic RV32M reference.
module tb_div_unit;
   import div_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   div_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

   div_unit #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (5)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      div_op_e     op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   int          checks = 0;
   int          failures = 0;
   vec_t        vt [12];
   int          lat1, lat2, bc, wc;
   logic [31:0] wd1, wd2;
   logic [4:0]  wa1, wa2;
   logic        seen_we, seen_busy;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input div_op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (op)
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REMU: return (b == 0) ? a : a % b;
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         default: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(sa % sb);
         end
      endcase
   endfunction

   function automatic int ref_lat(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic sgn;
      sgn = (op == OP_DIV) || (op == OP_REM);
      if (b == 0) return 1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic drive_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.rs1_i   = a;
      bus.rs2_i   = b;
      bus.rd_i    = rd;
   endtask

   // Issue one op, then wait (bounded) for the write pulse; lat=0 means it never came.
   task automatic do_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output logic [31:0] wd,
                        output logic [4:0] wa);
      drive_op(op, a, b, rd);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      lat = 0;
      wd  = '0;
      wa  = '0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (bus.we_o) begin
            lat = i;
            wd  = bus.wd_o;
            wa  = bus.waddr_o;
            break;
         end
      end
   endtask

   // Count busy/we samples from just after E0 through E44.
   task automatic profile(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int busy_cnt, output int we_cnt);
      drive_op(op, a, b, rd);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      busy_cnt = 0;
      we_cnt   = 0;
      for (int i = 0; i < 45; i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         busy_cnt += int'(bus.busy_o);
         we_cnt   += int'(bus.we_o);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0]  = '{OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33};
      vt[1]  = '{OP_REMU, 32'd100, 32'd7, 5'd5, 32'd2, 33};
      vt[2]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33};
      vt[3]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33};
      vt[4]  = '{OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'hFFFF_FFFD, 33};
      vt[5]  = '{OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'd1, 33};
      vt[6]  = '{OP_DIVU, 32'd5, 32'd0, 5'd6, 32'hFFFF_FFFF, 1};
      vt[7]  = '{OP_REMU, 32'd5, 32'd0, 5'd7, 32'd5, 1};
      vt[8]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000, 1};
      vt[9]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 1};
      vt[10] = '{OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFB, 1};
      vt[11] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 32'd0, 33};

      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.op_i    = OP_DIVU;
      bus.rs1_i   = '0;
      bus.rs2_i   = '0;
      bus.rd_i    = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", bus.busy_o, 0);
      chk("reset_we", bus.we_o, 0);
      chk("reset_waddr", bus.waddr_o, 0);
      chk("reset_wd", bus.wd_o, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].rd, lat1, wd1, wa1);
         chk($sformatf("vec%0d_lat", i), lat1, vt[i].lat);
         chk($sformatf("vec%0d_wd", i), wd1, vt[i].exp);
         chk($sformatf("vec%0d_waddr", i), wa1, vt[i].rd);
         chk($sformatf("vec%0d_busy_wb", i), bus.busy_o, 0);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_we_drop", i), bus.we_o, 0);
         chk($sformatf("vec%0d_wd_hold", i), bus.wd_o, vt[i].exp);
      end

      // Flush mid-CALC, with a competing start in the same cycle.
      drive_op(OP_DIVU, 32'd100, 32'd7, 5'd5);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("flush_busy_before", bus.busy_o, 1);
      bus.flush_i = 1'b1;
      drive_op(OP_DIVU, 32'd9, 32'd3, 5'd6);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;
      chk("flush_busy_after", bus.busy_o, 0);
      seen_we = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         seen_we |= bus.we_o;
         seen_busy |= bus.busy_o;
      end
      chk("flush_no_we", seen_we, 0);
      chk("flush_start_ignored", seen_busy, 0);

      // Flush held in IDLE blocks acceptance.
      bus.flush_i = 1'b1;
      drive_op(OP_DIVU, 32'd9, 32'd3, 5'd6);
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;
      chk("idle_flush_blocks", bus.busy_o, 0);

      profile(OP_DIVU, 32'd100, 32'd7, 5'd0, bc, wc);
      chk("rd0_busy_cycles", bc, 33);
      chk("rd0_no_we", wc, 0);
      profile(OP_DIVU, 32'd100, 32'd7, 5'd5, bc, wc);
      chk("rd5_busy_cycles", bc, 33);
      chk("rd5_one_we", wc, 1);

      // Second op issued in the first op's write-back cycle.
      do_op(OP_DIVU, 32'd100, 32'd7, 5'd5, lat1, wd1, wa1);
      do_op(OP_REMU, 32'd100, 32'd7, 5'd9, lat2, wd2, wa2);
      chk("b2b_lat1", lat1, 33);
      chk("b2b_wd1", wd1, 14);
      chk("b2b_spacing", lat2 + 1, 34);
      chk("b2b_wd2", wd2, 2);
      chk("b2b_waddr2", wa2, 9);

      // Asynchronous reset in the middle of an op.
      drive_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd3);
      @(posedge clk);
      #1 bus.start_i = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_we", bus.we_o, 0);
      chk("rst_wd", bus.wd_o, 0);
      chk("rst_waddr", bus.waddr_o, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      seen_we = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         seen_we |= bus.we_o;
      end
      chk("rst_no_wb", seen_we, 0);
      do_op(OP_DIVU, 32'd9, 32'd3, 5'd7, lat1, wd1, wa1);
      chk("post_rst_lat", lat1, 33);
      chk("post_rst_wd", wd1, 3);
      chk("post_rst_waddr", wa1, 7);

      // Randomized ops against the reference model.
      for (int i = 0; i < 150; i++) begin
         div_op_e     op;
         logic [31:0] a, b;
         logic [4:0]  rd;
         int          sel;
         op  = div_op_e'($urandom_range(0, 3));
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = $urandom;
         rd  = 5'($urandom_range(1, 31));
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (sel == 2) b = $urandom_range(1, 15);
         else if (sel == 3) b = -$urandom_range(1, 15);
         do_op(op, a, b, rd, lat1, wd1, wa1);
         chk($sformatf("rnd%0d_op%0d_%0h_%0h_wd", i, op, a, b), wd1, ref_res(op, a, b));
         chk($sformatf("rnd%0d_lat", i), lat1, ref_lat(op, a, b));
         chk($sformatf("rnd%0d_waddr", i), wa1, rd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider beside the register file. It consumes the two register read operands and returns the quotient or remainder to the register file write port as a one-cycle write pulse. It is restoring radix-2 with one quotient bit per cycle. Division by zero and signed overflow are short-circuited. The hazard logic stalls issue on `busy_o`.

## Interface
- `DATA_WIDTH`, 32, operand/result width.
- `ADDRESS_WIDTH`, 5, destination register index width.

- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request; accepted when `start_i && !busy_o && !flush_i`.
- `op_i`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_i`  in  DATA_WIDTH  dividend (register file read port 1).
- `rs2_i`  in  DATA_WIDTH  divisor (register file read port 2).
- `rd_i`  in  ADDRESS_WIDTH  destination register index.
- `flush_i`  in  1  abort in-flight op; no write is produced.
- `busy_o`  out  1  op in flight; equals state != IDLE.
- `we_o`  out  1  one-cycle write pulse to the register file write enable.
- `waddr_o`  out  ADDRESS_WIDTH  write address, valid while `we_o` is high.
- `wd_o`  out  DATA_WIDTH  write data, valid while `we_o` is high.

## Operation
- States:
  - IDLE: on accept, go to CALC (normal op) or FIX (special case).
  - CALC: advances to FIX after DATA_WIDTH iterations.
  - FIX: goes to IDLE while registering the result.
- On accept, latch the following: op, rd, the sign flags, |rs1|, |rs2| (magnitudes taken only for DIV/REM), and special-case flags. Clear the remainder register and the iteration counter (width $clog2(DATA_WIDTH)+1).
- CALC iteration:
  - Shift {rem, quo} left by 1, bringing in the next dividend MSB.
  - If rem ≥ divisor, subtract and set the quotient LSB.
  - The subtractor is DATA_WIDTH+1 bits wide; there is no truncation.
- FIX sign correction:
  - Quotient is negated when the operand signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - Unsigned ops use raw values.
- Divide by zero: quotient = all ones, remainder = rs1. CALC is bypassed.
- Signed overflow (rs1 = 0x8000_0000, rs2 = all ones, DIV/REM): quotient = 0x8000_0000, remainder = 0. CALC is bypassed.
- rd = 0: the op runs normally, but `we_o` stays low. The register file does not guard x0.
- `flush_i` priority:
  - In any non-IDLE state, flush returns the block to IDLE at the next edge, with no `we_o`.
  - In IDLE, flush blocks acceptance.
- `start_i` while busy is ignored. Upstream holds it under stall.

## Timing
- Reset values:
  - All outputs 0: `busy_o` = 0, `we_o` = 0, `waddr_o` = 0, `wd_o` = 0.
  - State IDLE; all internal registers 0.
- Edge numbering: acceptance edge = E0.
- Normal latency: CALC iterations happen at E1..E(DATA_WIDTH). FIX registers the outputs at E(DATA_WIDTH+1). `we_o` is high for exactly the cycle after that edge (E33 for the default).
- Special-case latency: FIX at E1, so `we_o` is high the cycle after E1.
- `busy_o` drops at the same edge that raises `we_o`. A new op may be accepted in the write-back cycle, giving back-to-back throughput of DATA_WIDTH+2 cycles.
- `we_o`, `waddr_o` and `wd_o` are registered, with no combinational path from inputs. `we_o` returns to 0 the following edge; `wd_o` and `waddr_o` hold their values.
- Asynchronous reset mid-op: immediate return to IDLE with outputs 0. There is no write-back after reset release.

## Structure
- Shared package `div_pkg`:
  - `div_op_e` enum (DIV/DIVU/REM/REMU, 2 bits).
  - `div_state_e` enum (IDLE/CALC/FIX).
  - `DIV_ZERO_Q` constant = all ones.
- One combinational sub-module, `div_step`: one restoring iteration (rem, quo, divisor in; rem, quo out). It is instantiated once inside `div_unit`.

## Test plan
- DIVU 100/7, rd = 5 → `we_o` high one cycle after E33, `wd_o` = 14, `waddr_o` = 5. REMU with the same operands → 2.
- DIV −7/2 → 0xFFFF_FFFD. REM −7/2 → 0xFFFF_FFFF. DIV 7/−2 → 0xFFFF_FFFD. REM 7/−2 → 1.
- DIVU 5/0 → 0xFFFF_FFFF after E1. REMU 5/0 → 5. DIV 0x8000_0000/0xFFFF_FFFF → 0x8000_0000. REM with the same operands → 0.
- `flush_i` pulsed at E10 of DIVU 100/7 → `busy_o` = 0 after E11 and `we_o` never asserts. A DIVU 9/3 accepted in the same cycle as the flush is ignored.
- DIVU 100/7 with rd = 0 → `busy_o` profile identical to the normal case, `we_o` never high. Back-to-back: a second op accepted in the write-back cycle of the first → both results written, 34 cycles apart.
- `rst_ni` low at E15 of an op → `busy_o`, `we_o` and `wd_o` are 0 immediately. After release, no write occurs and a new op is accepted normally.
